// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-ported, combinationally-read data memory.
// Latency from accepting edge to resp_valid: error 1, load 2, word store 2, sub-word store 3.
// No backpressure on responses; req_ready is high only while idle, so requests wait upstream.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (accepted on posedge when both high)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                       one-cycle completion pulse
//   dm_address, dm_write, dm_wdata, dm_rdata               data memory port (word indexed)
module mem_access_unit #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_address,
    output logic        dm_write,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;
    localparam logic [1:0]  SZ_ILL   = 2'b11;
    localparam logic [31:0] DM_LIMIT = 32'(DM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;

    // Captured request. The word part of the address lives in dm_address,
    // so only the byte offset within the word is kept here.
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] wdata_q;

    // Request decode, evaluated on the incoming request while idle.
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_error;

    always_comb begin
        req_misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                           ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
        req_out_of_range = ({2'b00, req_addr[31:2]} >= DM_LIMIT);
        req_error        = (req_size == SZ_ILL) || req_misaligned || req_out_of_range;
    end

    // Read-modify-write merge: the word read in RD with only the addressed lane replaced.
    logic [31:0] merged;

    always_comb begin
        merged = dm_rdata;
        case (size_q)
            SZ_BYTE: merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
            SZ_HALF: merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    logic [31:0] lane;
    logic [31:0] load_ext;

    always_comb begin
        lane = dm_rdata >> {off_q, 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
            SZ_HALF: load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: load_ext = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            dm_address <= 32'h0;
            dm_write   <= 1'b0;
            dm_wdata   <= 32'h0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'h0;
                        if (req_error) begin
                            // Memory is never touched for a bad request.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            dm_address <= {2'b00, req_addr[31:2]};
                            if (req_write && (req_size == SZ_WORD)) begin
                                // Whole-word store needs no read.
                                state    <= WR;
                                dm_write <= 1'b1;
                                dm_wdata <= req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end

                RD: begin
                    if (write_q) begin
                        state    <= WR;
                        dm_write <= 1'b1;
                        dm_wdata <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                    end
                end

                WR: begin
                    state      <= RESP;
                    dm_write   <= 1'b0;
                    resp_valid <= 1'b1;
                end

                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    dm_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// requests checked against a byte-addressed reference memory model.
module tb_mem_access_unit;

    localparam int DM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_address;
    logic        dm_write;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    mem_access_unit #(.DM_WORDS(DM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_address (dm_address),
        .dm_write   (dm_write),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    // Bench-side data memory with a preload port.
    logic [31:0] mem [0:DM_WORDS-1];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = 10'd0;
    logic [31:0] pre_dat = 32'h0;
    int          wr_count = 0;
    int          resp_count = 0;

    always @(posedge clk) begin
        if (dm_write) begin
            if (dm_address < 32'(DM_WORDS)) mem[dm_address[9:0]] <= dm_wdata;
            wr_count <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_dat;
        end
        if (resp_valid) resp_count <= resp_count + 1;
    end

    always_comb begin
        dm_rdata = 32'h0;
        if (dm_address < 32'(DM_WORDS)) dm_rdata = mem[dm_address[9:0]];
    end

    // Reference model: memory as a flat byte array.
    logic [7:0] ref_bytes [0:DM_WORDS*4-1];
    int tests = 0;
    int fails = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd,
                         output int lat, output int nw);
        int n;
        logic [31:0] v;
        n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        e  = (sz == 2'b11) || ((a % n) != 0) || ((a / 4) >= DM_WORDS);
        rd = 32'h0;
        if (e) begin
            lat = 1;
            nw  = 0;
        end else if (w) begin
            for (int i = 0; i < n; i++) ref_bytes[int'(a[11:0]) + i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
            nw  = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a[11:0]) + i]) << (8*i));
            if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd  = v;
            lat = 2;
            nw  = 0;
        end
    endtask

    // Drives one request and observes its completion. lat = -1 if no response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e,
                          output int nw, output logic [31:0] addr_seen, output int waits);
        int wr0;
        int cnt;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        wr0 = wr_count;
        #1;
        req_valid = 1'b0;
        addr_seen = dm_address;
        rd = 32'h0;
        e = 1'b0;
        cnt = 1;
        while (!resp_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (resp_valid) begin
            lat = cnt;
            rd  = resp_rdata;
            e   = resp_err;
        end else begin
            lat = -1;
        end
        @(posedge clk);
        #1;
        nw = wr_count - wr0;
    endtask

    task automatic preload();
        logic [31:0] d;
        for (int i = 0; i < DM_WORDS*4; i++) ref_bytes[i] = 8'h00;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            d = (i == 5) ? 32'h80FF_1234 : (i == 2) ? 32'h1122_3344 : $urandom;
            pre_we = 1'b1; pre_idx = 10'(i); pre_dat = d;
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = d[8*b +: 8];
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
        tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
        tests++; if (dm_write !== 1'b0) begin fails++; $display("FAIL rst_dm_write got %b exp 0", dm_write); end
        tests++; if (dm_address !== 32'h0) begin fails++; $display("FAIL rst_dm_address got %h exp 0", dm_address); end
        tests++; if (dm_wdata !== 32'h0) begin fails++; $display("FAIL rst_dm_wdata got %h exp 0", dm_wdata); end
    endtask

    task automatic test_signed_byte_load();
        int lat, nw, wt; logic [31:0] rd, as; logic e;
        do_req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, lat, rd, e, nw, as, wt);
        tests++; if (as !== 32'd5) begin fails++; $display("FAIL lb_addr got %0d exp 5", as); end
        tests++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata got %h exp ffffff80", rd); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL lb_latency got %0d exp 2", lat); end
        tests++; if (e !== 1'b0 || nw !== 0) begin fails++; $display("FAIL lb_err_wr got err=%b writes=%0d exp 0/0", e, nw); end
    endtask

    task automatic test_subword_store();
        int lat, nw, wt, mlat, mnw; logic [31:0] rd, as, mrd; logic e, me;
        model(1'b1, 2'b01, 1'b0, 32'h0A, 32'hAAAA_BEEF, me, mrd, mlat, mnw);
        do_req(1'b1, 2'b01, 1'b0, 32'h0A, 32'hAAAA_BEEF, lat, rd, e, nw, as, wt);
        tests++; if (nw !== 1) begin fails++; $display("FAIL sh_writes got %0d exp 1", nw); end
        tests++; if (mem[2] !== 32'hBEEF_3344) begin fails++; $display("FAIL sh_mem got %h exp beef3344", mem[2]); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL sh_latency got %0d exp 3", lat); end
        tests++; if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sh_resp got rdata=%h err=%b exp 0/0", rd, e); end
    endtask

    task automatic test_word_store();
        int lat, nw, wt, mlat, mnw; logic [31:0] rd, as, mrd; logic e, me;
        model(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, me, mrd, mlat, mnw);
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, lat, rd, e, nw, as, wt);
        tests++; if (as !== 32'd16) begin fails++; $display("FAIL sw_addr got %0d exp 16", as); end
        tests++; if (nw !== 1) begin fails++; $display("FAIL sw_writes got %0d exp 1", nw); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got %0d exp 2", lat); end
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, e, nw, as, wt);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_after_sw got %h exp deadbeef", rd); end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h42, 32'h03, 32'h10, 32'h1000};
        int lat, nw, wt; logic [31:0] rd, as; logic e;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, lat, rd, e, nw, as, wt);
            tests++; if (e !== 1'b1 || lat !== 1) begin fails++; $display("FAIL err%0d got err=%b lat=%0d exp 1/1", i, e, lat); end
            tests++; if (nw !== 0 || rd !== 32'h0) begin fails++; $display("FAIL err%0d_side got writes=%0d rdata=%h exp 0/0", i, nw, rd); end
        end
        // Error stores must not write either.
        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, lat, rd, e, nw, as, wt);
        tests++; if (e !== 1'b1 || nw !== 0) begin fails++; $display("FAIL err_store got err=%b writes=%0d exp 1/0", e, nw); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2, rdk [7];
        logic rv [7], rr [7];
        logic ve, ve2; int vl, vn;
        model(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, ve, exp1, vl, vn);
        model(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, ve2, exp2, vl, vn);
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h14;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 32'h16;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            rv[k] = resp_valid; rr[k] = req_ready; rdk[k] = resp_rdata;
            if (k == 4) req_valid = 1'b0;
        end
        for (int k = 1; k <= 6; k++) begin
            tests++;
            if (rv[k] !== (k == 2 || k == 5)) begin fails++; $display("FAIL b2b_valid[%0d] got %b exp %b", k, rv[k], (k == 2 || k == 5)); end
            tests++;
            if (rr[k] !== (k == 3 || k == 6)) begin fails++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, rr[k], (k == 3 || k == 6)); end
        end
        tests++; if (rdk[2] !== exp1) begin fails++; $display("FAIL b2b_data1 got %h exp %h", rdk[2], exp1); end
        tests++; if (rdk[5] !== exp2) begin fails++; $display("FAIL b2b_data2 got %h exp %h", rdk[5], exp2); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] m0, rd, as, mrd; int w0, r0, lat, nw, wt, mlat, mnw; logic e, me;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h0D; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        m0 = mem[3]; w0 = wr_count; r0 = resp_count;
        @(posedge clk);
        #1;
        tests++; if (dm_write !== 1'b1) begin fails++; $display("FAIL mr_in_wr got dm_write=%b exp 1", dm_write); end
        rst_n = 1'b0;
        #1;
        tests++; if (req_ready !== 1'b1 || dm_write !== 1'b0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL mr_async got ready=%b wr=%b rv=%b exp 1/0/0", req_ready, dm_write, resp_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++; if (mem[3] !== m0 || wr_count !== w0) begin fails++; $display("FAIL mr_mem got %h writes=%0d exp %h writes=%0d", mem[3], wr_count, m0, w0); end
        tests++; if (resp_count !== r0) begin fails++; $display("FAIL mr_resp got %0d exp %0d", resp_count, r0); end
        model(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, me, mrd, mlat, mnw);
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, rd, e, nw, as, wt);
        tests++; if (wt !== 0 || lat !== 2) begin fails++; $display("FAIL mr_first_accept got waits=%0d lat=%0d exp 0/2", wt, lat); end
        tests++; if (rd !== mrd) begin fails++; $display("FAIL mr_reload got %h exp %h", rd, mrd); end
        tests++; if (resp_count !== r0 + 1) begin fails++; $display("FAIL mr_resp_after got %0d exp %0d", resp_count, r0 + 1); end
    endtask

    task automatic test_random();
        logic w, sg, e, me; logic [1:0] sz; logic [31:0] a, wd, rd, mrd, as, wordi, word;
        int lat, nw, wt, mlat, mnw;
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            wordi = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1020, 1100)) : 32'($urandom_range(0, 31));
            a  = {wordi[29:0], 2'($urandom_range(0, 3))};
            if (i == 40) a = 32'hFFFF_FFFC;
            model(w, sz, sg, a, wd, me, mrd, mlat, mnw);
            do_req(w, sz, sg, a, wd, lat, rd, e, nw, as, wt);
            tests++;
            if (e !== me || rd !== mrd || lat !== mlat || nw !== mnw) begin
                fails++;
                $display("FAIL rnd%0d w=%b sz=%b sg=%b a=%h got err=%b rd=%h lat=%0d nw=%0d exp err=%b rd=%h lat=%0d nw=%0d",
                         i, w, sz, sg, a, e, rd, lat, nw, me, mrd, mlat, mnw);
            end
        end
        for (int i = 0; i < 32; i++) begin
            word = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
            tests++;
            if (mem[i] !== word) begin fails++; $display("FAIL mem_final[%0d] got %h exp %h", i, mem[i], word); end
        end
    endtask

    initial begin
        preload();
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_signed_byte_load();
        test_subword_store();
        test_word_store();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DM_WORDS, default 1024, number of 32-bit words in the data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 SHALL have port req_addr  input  32  byte address from the ALU.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  qualified by resp_valid: misaligned, illegal size or out-of-range request.
REQ-014 SHALL have port dm_address  output  32  word index to data memory (byte address >> 2).
REQ-015 SHALL have port dm_write  output  1  data memory write strobe, sampled at posedge clk.
REQ-016 SHALL have port dm_wdata  output  32  full word written to data memory.
REQ-017 SHALL have port dm_rdata  input  32  combinational read data for dm_address.

Function
REQ-018 SHALL implement states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept on posedge when IDLE and req_valid = 1, and register addr, size, signed, write and wdata.
REQ-020 SHALL flag an error when size = 11, halfword with addr[0] = 1, word with addr[1:0] != 0, or addr[31:2] >= DM_WORDS.
REQ-021 SHALL go IDLE -> RESP on an error request and never assert dm_write for it.
REQ-022 SHALL go IDLE -> RD -> RESP for a load; in RD drive dm_address and capture dm_rdata at the end of the cycle.
REQ-023 SHALL go IDLE -> WR -> RESP for a word store; in WR assert dm_write = 1 for exactly one cycle with dm_wdata = req_wdata.
REQ-024 SHALL go IDLE -> RD -> WR -> RESP for a byte or halfword store (read-modify-write).
REQ-025 SHALL, in the sub-word store WR cycle, write the captured word with only the addressed lane replaced.
REQ-026 SHALL use little-endian lanes: byte offset k occupies bits 8k+7:8k; halfword offset 0 is bits 15:0 and offset 2 is bits 31:16.
REQ-027 SHALL extract the addressed lane on loads and sign- or zero-extend it to 32 bits per req_signed; req_signed is ignored for word loads.
REQ-028 SHALL assert resp_valid for exactly one cycle in RESP and then return to IDLE; the consumer is always ready (no backpressure).
REQ-029 SHALL give latencies counted from the accepting edge to the resp_valid cycle: error 1, load 2, word store 2, sub-word store 3.
REQ-030 SHALL drive dm_write = 0 in every state except WR.
REQ-031 SHALL hold dm_address and dm_wdata stable for the whole duration of RD and WR.
REQ-032 SHALL ignore req_valid while not IDLE; a request held across busy cycles is accepted on the first IDLE edge.
REQ-033 SHALL, in RESP, drive resp_rdata = 0 and resp_err = 0 for successful stores.

Reset
REQ-034 SHALL, on rst_n = 0, immediately force: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, dm_write = 0, dm_address = 0, dm_wdata = 0.
REQ-035 SHALL abandon any in-flight request on reset with no memory write and no response, including a reset asserted during WR.
REQ-036 SHALL accept a new request on the first posedge after rst_n deasserts.

Verification
REQ-037 SHALL check the signed byte load: mem[5] = 0x80FF_1234, lb (signed) addr 0x17 -> dm_address = 5, resp_rdata = 0xFFFF_FF80 two cycles after accept.
REQ-038 SHALL check the sub-word store: mem[2] = 0x1122_3344, sh addr 0x0A with wdata 0xAAAA_BEEF -> one dm_write with 0xBEEF_3344, resp_valid three cycles after accept.
REQ-039 SHALL check the word store: sw addr 0x40 with wdata 0xDEAD_BEEF -> dm_address = 16, one dm_write, then lw addr 0x40 returns 0xDEAD_BEEF.
REQ-040 SHALL check error requests: lw addr 0x42, lh addr 0x03, size 11, and lw addr 0x1000 with DM_WORDS = 1024 -> resp_err = 1 one cycle after accept, dm_write never asserted.
REQ-041 SHALL check mid-operation reset: rst_n pulsed low during the WR of an sb -> memory unchanged, no resp_valid, req_ready = 1 immediately.
REQ-042 SHALL check back-to-back requests: req_valid held high with two lbu requests -> second accepted on the cycle after the first resp_valid, req_ready low in between.
